// File: rtl/fir_datapath.sv
// FIR filter datapath: one micro-op per clock on a 16 x 17-bit signed register file.
// Define DATAPATH_SAT_EN to saturate ADD/SUB/MUL results on overflow instead of wrapping.
module fir_datapath #(
  parameter int NREGS     = 16,
  parameter int RWIDTH    = 17,
  parameter int FRAC_BITS = 15
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        op,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  input  logic [3:0]        dest,
  input  logic [15:0]       ext_data1,
  input  logic [15:0]       ext_data2,
  output logic              overflow,
  output logic [RWIDTH-1:0] outreg_data,
  output logic [15:0]       fir_out
);

  localparam int SW = RWIDTH + 1;
  localparam int PW = 2 * RWIDTH;

  typedef enum logic [2:0] {
    OP_NOP         = 3'b000,
    OP_COPY        = 3'b001,
    OP_LOAD_SAMPLE = 3'b010,
    OP_LOAD_COEF   = 3'b011,
    OP_ADD         = 3'b100,
    OP_SUB         = 3'b101,
    OP_MUL         = 3'b110,
    OP_RSVD        = 3'b111
  } op_t;

  op_t                      op_e;
  logic signed [RWIDTH-1:0] regs_q [NREGS];
  logic [15:0]              fir_q, fir_d;
  logic signed [RWIDTH-1:0] a, b, result_d;
  logic signed [SW-1:0]     sum_w, diff_w;
  logic signed [PW-1:0]     prod_w, shifted_w;
  logic [SW-1:0]            mag_w;
  logic                     wr_en, ovf, res_neg;
  logic                     sum_ovf, diff_ovf, mul_ovf;

  assign op_e = op_t'(op);
  assign a    = regs_q[src1];
  assign b    = regs_q[src2];

  // Widened by one bit so the carry into the sign position is visible.
  assign sum_w     = SW'(a) + SW'(b);
  assign diff_w    = SW'(a) - SW'(b);
  assign prod_w    = PW'(a) * PW'(b);
  assign shifted_w = prod_w >>> FRAC_BITS;

  assign sum_ovf  = sum_w[SW-1] != sum_w[SW-2];
  assign diff_ovf = diff_w[SW-1] != diff_w[SW-2];
  assign mul_ovf  = shifted_w[PW-1:RWIDTH-1] != {(PW-RWIDTH+1){shifted_w[PW-1]}};

  always_comb begin
    result_d = '0;
    wr_en    = 1'b0;
    ovf      = 1'b0;
    res_neg  = 1'b0;
    case (op_e)
      OP_COPY: begin
        result_d = a;
        wr_en    = 1'b1;
      end
      OP_LOAD_SAMPLE: begin
        result_d = RWIDTH'(ext_data1);
        wr_en    = 1'b1;
      end
      OP_LOAD_COEF: begin
        result_d = RWIDTH'(ext_data2);
        wr_en    = 1'b1;
      end
      OP_ADD: begin
        result_d = sum_w[RWIDTH-1:0];
        ovf      = sum_ovf;
        res_neg  = sum_w[SW-1];
        wr_en    = 1'b1;
      end
      OP_SUB: begin
        result_d = diff_w[RWIDTH-1:0];
        ovf      = diff_ovf;
        res_neg  = diff_w[SW-1];
        wr_en    = 1'b1;
      end
      OP_MUL: begin
        result_d = shifted_w[RWIDTH-1:0];
        ovf      = mul_ovf;
        res_neg  = shifted_w[PW-1];
        wr_en    = 1'b1;
      end
      default: ;
    endcase
`ifdef DATAPATH_SAT_EN
    if (ovf) begin
      result_d = res_neg ? {1'b1, {(RWIDTH-1){1'b0}}} : {1'b0, {(RWIDTH-1){1'b1}}};
    end
`endif
  end

  // Magnitude needs one extra bit: |most negative| does not fit RWIDTH signed.
  always_comb begin
    mag_w = result_d[RWIDTH-1] ? -SW'(result_d) : SW'(result_d);
    fir_d = fir_q;
    if (wr_en && (dest == 4'd0)) begin
      fir_d = (|mag_w[SW-1:16]) ? 16'hFFFF : mag_w[15:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      fir_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[dest] <= result_d;
      end
      fir_q <= fir_d;
    end
  end

  assign overflow    = ovf;
  assign outreg_data = regs_q[0];
  assign fir_out     = fir_q;

endmodule

// File: tb/tb_fir_datapath.sv
// Self-checking bench for fir_datapath: directed scenarios plus random ops against an
// arithmetic reference model. Honours DATAPATH_SAT_EN the same way the design does.
module tb_fir_datapath;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  op;
  logic [3:0]  src1, src2, dest;
  logic [15:0] ext_data1, ext_data2;
  logic        overflow;
  logic [16:0] outreg_data;
  logic [15:0] fir_out;

  int total = 0;
  int bad   = 0;

  longint m_regs [16];
  longint m_fir;

  localparam bit [2:0] NOP = 3'd0, CPY = 3'd1, LDS = 3'd2, LDC = 3'd3,
                       ADD = 3'd4, SUB = 3'd5, MUL = 3'd6, RSV = 3'd7;

  fir_datapath dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .dest       (dest),
    .ext_data1  (ext_data1),
    .ext_data2  (ext_data2),
    .overflow   (overflow),
    .outreg_data(outreg_data),
    .fir_out    (fir_out)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_fir = 0;
  endfunction

  // Values are held as plain integers in [-65536, 65535].
  function automatic bit model_step(bit [2:0] o, bit [3:0] s1, bit [3:0] s2, bit [3:0] d,
                                    bit [15:0] e1, bit [15:0] e2);
    longint x = m_regs[s1];
    longint y = m_regs[s2];
    longint r = 0;
    longint mag;
    bit wr = 1'b1;
    bit ov = 1'b0;
    case (o)
      CPY: r = x;
      LDS: r = longint'(e1);
      LDC: r = longint'(e2);
      ADD: r = x + y;
      SUB: r = x - y;
      MUL: r = (x * y) >>> 15;
      default: wr = 1'b0;
    endcase
    if (o == ADD || o == SUB || o == MUL) ov = (r > 65535) || (r < -65536);
    if (wr) begin
      if (ov) begin
`ifdef DATAPATH_SAT_EN
        r = (r < 0) ? -65536 : 65535;
`else
        r = r % 131072;
        if (r < 0) r += 131072;
        if (r > 65535) r -= 131072;
`endif
      end
      m_regs[d] = r;
      if (d == 0) begin
        mag   = (r < 0) ? -r : r;
        m_fir = (mag > 65535) ? 65535 : mag;
      end
    end
    return ov;
  endfunction

  task automatic run_op(input bit [2:0] o, input bit [3:0] s1, input bit [3:0] s2,
                        input bit [3:0] d, input bit [15:0] e1, input bit [15:0] e2,
                        output logic ovf_obs, output bit ovf_exp);
    @(negedge clk);
    op = o; src1 = s1; src2 = s2; dest = d; ext_data1 = e1; ext_data2 = e2;
    #1;
    ovf_obs = overflow;
    ovf_exp = model_step(o, s1, s2, d, e1, e2);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op = NOP; src1 = 0; src2 = 0; dest = 0; ext_data1 = 0; ext_data2 = 0;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (outreg_data !== 17'h0) begin bad++; $display("FAIL reset_outreg: got %h want 00000", outreg_data); end
    total++; if (fir_out !== 16'h0) begin bad++; $display("FAIL reset_fir: got %h want 0000", fir_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_loads();
    logic ov; bit oe;
    run_op(LDC, 0, 0, 6, 16'h0, 16'h8000, ov, oe);
    run_op(LDS, 0, 0, 1, 16'h1234, 16'h0, ov, oe);
    run_op(MUL, 1, 6, 10, 16'h0, 16'h0, ov, oe);
    total++; if (ov !== 1'b0 || oe !== 1'b0) begin bad++; $display("FAIL loads_mul_ovf: got %b want 0", ov); end
    run_op(CPY, 10, 0, 0, 16'h0, 16'h0, ov, oe);
    total++; if (outreg_data !== 17'h01234) begin bad++; $display("FAIL loads_r10: got %h want 01234", outreg_data); end
  endtask

  task automatic test_accumulate();
    logic ov; bit oe;
    run_op(SUB, 5, 5, 0, 16'h0, 16'h0, ov, oe);
    total++; if (outreg_data !== 17'h0 || fir_out !== 16'h0) begin bad++; $display("FAIL acc_zero: got %h/%h want 00000/0000", outreg_data, fir_out); end
    run_op(ADD, 0, 10, 0, 16'h0, 16'h0, ov, oe);
    total++; if (outreg_data !== 17'h01234) begin bad++; $display("FAIL acc_add_outreg: got %h want 01234", outreg_data); end
    total++; if (fir_out !== 16'h1234) begin bad++; $display("FAIL acc_add_fir: got %h want 1234", fir_out); end
    run_op(SUB, 0, 10, 0, 16'h0, 16'h0, ov, oe);
    run_op(SUB, 0, 10, 0, 16'h0, 16'h0, ov, oe);
    total++; if (outreg_data !== 17'h1EDCC) begin bad++; $display("FAIL acc_sub_outreg: got %h want 1edcc", outreg_data); end
    total++; if (fir_out !== 16'h1234) begin bad++; $display("FAIL acc_sub_fir: got %h want 1234", fir_out); end
  endtask

  task automatic test_overflow();
    logic ov; bit oe;
    logic [16:0] exp_r0, exp_r13;
    logic [15:0] exp_f0, exp_f13;
`ifdef DATAPATH_SAT_EN
    exp_r0 = 17'h0FFFF; exp_f0 = 16'hFFFF; exp_r13 = 17'h10000; exp_f13 = 16'hFFFF;
`else
    exp_r0 = 17'h1FFFE; exp_f0 = 16'h0002; exp_r13 = 17'h00002; exp_f13 = 16'h0002;
`endif
    run_op(LDS, 0, 0, 1, 16'hFFFF, 16'h0, ov, oe);
    run_op(LDS, 0, 0, 2, 16'hFFFF, 16'h0, ov, oe);
    run_op(ADD, 1, 2, 0, 16'h0, 16'h0, ov, oe);
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL ovf_add_flag: got %b want 1", ov); end
    total++; if (outreg_data !== exp_r0) begin bad++; $display("FAIL ovf_add_r0: got %h want %h", outreg_data, exp_r0); end
    total++; if (fir_out !== exp_f0) begin bad++; $display("FAIL ovf_add_fir: got %h want %h", fir_out, exp_f0); end
    run_op(MUL, 1, 2, 7, 16'h0, 16'h0, ov, oe);
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL ovf_mul_flag: got %b want 1", ov); end
    run_op(SUB, 5, 1, 12, 16'h0, 16'h0, ov, oe);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL ovf_sub_edge_flag: got %b want 0", ov); end
    run_op(SUB, 12, 2, 13, 16'h0, 16'h0, ov, oe);
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL ovf_sub_flag: got %b want 1", ov); end
    run_op(CPY, 13, 0, 0, 16'h0, 16'h0, ov, oe);
    total++; if (outreg_data !== exp_r13) begin bad++; $display("FAIL ovf_sub_r13: got %h want %h", outreg_data, exp_r13); end
    total++; if (fir_out !== exp_f13) begin bad++; $display("FAIL ovf_sub_fir: got %h want %h", fir_out, exp_f13); end
  endtask

  task automatic test_read_before_write();
    logic ov; bit oe;
    logic [15:0] fir_before;
    run_op(LDS, 0, 0, 3, 16'd5, 16'h0, ov, oe);
    run_op(ADD, 3, 3, 3, 16'h0, 16'h0, ov, oe);
    run_op(CPY, 3, 0, 0, 16'h0, 16'h0, ov, oe);
    total++; if (outreg_data !== 17'd10) begin bad++; $display("FAIL rbw_add: got %h want 0000a", outreg_data); end
    fir_before = fir_out;
    run_op(NOP, 1, 2, 3, 16'h7777, 16'h7777, ov, oe);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL rbw_nop_ovf: got %b want 0", ov); end
    total++; if (fir_out !== fir_before) begin bad++; $display("FAIL rbw_nop_fir: got %h want %h", fir_out, fir_before); end
    run_op(RSV, 1, 2, 3, 16'h7777, 16'h7777, ov, oe);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL rbw_rsv_ovf: got %b want 0", ov); end
    run_op(RSV, 1, 2, 0, 16'h7777, 16'h7777, ov, oe);
    total++; if (outreg_data !== 17'd10 || fir_out !== fir_before) begin bad++; $display("FAIL rbw_rsv_r0: got %h/%h want 0000a/%h", outreg_data, fir_out, fir_before); end
    run_op(CPY, 3, 0, 0, 16'h0, 16'h0, ov, oe);
    total++; if (outreg_data !== 17'd10) begin bad++; $display("FAIL rbw_r3_kept: got %h want 0000a", outreg_data); end
  endtask

  task automatic test_back_to_back();
    logic ov; bit oe;
    run_op(SUB, 5, 5, 0, 16'h0, 16'h0, ov, oe);
    run_op(LDS, 0, 0, 4, 16'h4000, 16'h0, ov, oe);
    run_op(LDC, 0, 0, 9, 16'h0, 16'h4000, ov, oe);
    run_op(LDS, 0, 0, 10, 16'h0007, 16'h0, ov, oe);
    run_op(MUL, 4, 9, 10, 16'h0, 16'h0, ov, oe);
    run_op(ADD, 0, 10, 0, 16'h0, 16'h0, ov, oe);
    total++; if (outreg_data !== 17'h02000) begin bad++; $display("FAIL b2b_outreg: got %h want 02000", outreg_data); end
    total++; if (fir_out !== 16'h2000) begin bad++; $display("FAIL b2b_fir: got %h want 2000", fir_out); end
  endtask

  task automatic test_reset_mid_op();
    logic ov; bit oe;
    for (int i = 15; i >= 0; i--) begin
      run_op(LDS, 0, 0, 4'(i), 16'($urandom_range(1, 65535)), 16'h0, ov, oe);
    end
    @(negedge clk);
    op = MUL; src1 = 1; src2 = 2; dest = 10;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    total++; if (outreg_data !== 17'h0) begin bad++; $display("FAIL rstmid_outreg: got %h want 00000", outreg_data); end
    total++; if (fir_out !== 16'h0) begin bad++; $display("FAIL rstmid_fir: got %h want 0000", fir_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 1; i < 16; i++) begin
      run_op(CPY, 4'(i), 0, 0, 16'h0, 16'h0, ov, oe);
      total++; if (outreg_data !== 17'h0) begin bad++; $display("FAIL rstmid_r%0d: got %h want 00000", i, outreg_data); end
    end
  endtask

  task automatic test_random();
    logic ov; bit oe;
    bit [2:0] o;
    bit [3:0] s1, s2, d;
    for (int n = 0; n < 1000; n++) begin
      if (n % 24 == 0) begin
        o = SUB; s1 = 5; s2 = 5; d = 0;
      end else begin
        o  = 3'($urandom_range(0, 7));
        s1 = 4'($urandom_range(0, 15));
        s2 = 4'($urandom_range(0, 15));
        d  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        if (d == 4'd5) d = 4'd6;
      end
      run_op(o, s1, s2, d, 16'($urandom), 16'($urandom), ov, oe);
      total++; if (ov !== oe) begin bad++; $display("FAIL rnd_ovf[%0d] op=%0d: got %b want %b", n, o, ov, oe); end
      total++; if (outreg_data !== 17'(m_regs[0])) begin bad++; $display("FAIL rnd_outreg[%0d] op=%0d: got %h want %h", n, o, outreg_data, 17'(m_regs[0])); end
      total++; if (fir_out !== 16'(m_fir)) begin bad++; $display("FAIL rnd_fir[%0d] op=%0d: got %h want %h", n, o, fir_out, 16'(m_fir)); end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_accumulate();
    test_overflow();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
